// File: rtl/dcache_wbuf_pkg.sv
// Shared types for the data-cache posted-write buffer: FSM encoding and the
// buffered entry layout.
package dcache_wbuf_pkg;

  localparam int DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    WREQ,
    WRITE,
    RREQ,
    READ
  } state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// Write-buffer storage: circular FIFO with registered occupancy and a
// newest-match address lookup used for read forwarding.
module dcache_wbuf_fifo
  import dcache_wbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Nrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           push_entry_i,
  output entry_t           head_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic [29:0]      lk_waddr_i,
  output logic             hit_o,
  output logic [31:0]      hit_data_o
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  entry_t           mem_q [DEPTH];

  // Caller only pushes when not full and only pops when not empty.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Scan oldest to newest so the last match (the newest write) wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count_q) &&
          (mem_q[rd_ptr_q + PTR_W'(i)].waddr == lk_waddr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[rd_ptr_q + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/dcache_wbuf.sv
// Posted-write buffer between the data cache and the shared system bus.
// Bus outputs are zero unless this master owns the bus, so they can be OR-combined.
module dcache_wbuf
  import dcache_wbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rw_wait,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  state_e         state_q, state_d;
  entry_t         head;
  entry_t         new_entry;
  logic [PTR_W:0] count;
  logic           full, empty, hit;
  logic [31:0]    hit_data;
  logic           push, pop, rd_miss;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign new_entry = '{waddr: addr[31:2], data: wr_data};
  assign push      = wr_req & ~full;
  assign rd_miss   = rd_req & ~wr_req & ~hit;

  dcache_wbuf_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .Nrst         (Nrst),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (new_entry),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .lk_waddr_i   (addr[31:2]),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The grant cycle in WREQ/RREQ is already a strobe cycle; returning to
  // IDLE after every transfer guarantees a bus_req gap between transfers.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_miss)     state_d = RREQ;
        else if (!empty) state_d = WREQ;
      end
      WREQ, WRITE: begin
        bus_req = 1'b1;
        if (state_q == WRITE || bus_ack) begin
          bus_wr    = 1'b1;
          bus_addr  = {head.waddr, 2'b00};
          bus_wdata = head.data;
          if (bus_ready) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      RREQ, READ: begin
        bus_req = 1'b1;
        if (state_q == READ || bus_ack) begin
          bus_rd   = 1'b1;
          bus_addr = {addr[31:2], 2'b00};
          state_d  = bus_ready ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write wins over a simultaneous read; a full check uses the registered count.
  always_comb begin
    rw_wait = 1'b0;
    rd_data = '0;
    if (wr_req) begin
      rw_wait = full;
    end else if (rd_req) begin
      if (hit)                    rd_data = hit_data;
      else if (bus_rd && bus_ready) rd_data = bus_rdata;
      else                        rw_wait = 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed self-checking bench for dcache_wbuf with hand-computed expectations.
module tb_dcache_wbuf;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] addr;
  logic        rd_req, wr_req;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rw_wait;
  logic        bus_req, bus_ack;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .addr      (addr),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rw_wait   (rw_wait),
    .bus_req   (bus_req),
    .bus_ack   (bus_ack),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_req  = 1'b1;
    addr    = a;
    wr_data = d;
  endtask

  // Waits (bounded) for a completing write strobe, checks it, then moves on.
  task automatic drain_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    while (!(bus_wr && bus_ready) && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_strobe"}, {31'b0, bus_wr}, 32'd1);
    check({tag, "_addr"},   bus_addr,  a);
    check({tag, "_wdata"},  bus_wdata, d);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Nrst = 1'b0; addr = '0; rd_req = 1'b0; wr_req = 1'b0; wr_data = '0;
    bus_ack = 1'b0; bus_rdata = '0; bus_ready = 1'b0;
    #12;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_rw_wait", {31'b0, rw_wait}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_count", 32'(dut.u_fifo.count_o), 32'd0);
    tick();
    Nrst = 1'b1;

    // Single write drained with bus_ready on the second strobe cycle
    wr(32'h100, 32'h11); bus_ack = 1'b1; settle();
    check("t1_accept", {31'b0, rw_wait}, 32'd0);
    tick();
    wr_req = 1'b0; settle();
    check("t1_idle_no_req", {31'b0, bus_req}, 32'd0);
    tick();
    settle();
    check("t1_strobe1_wr", {31'b0, bus_wr}, 32'd1);
    check("t1_strobe1_addr", bus_addr, 32'h100);
    check("t1_strobe1_wdata", bus_wdata, 32'h11);
    tick();
    bus_ready = 1'b1; settle();
    check("t1_strobe2_wr", {31'b0, bus_wr}, 32'd1);
    check("t1_strobe2_addr", bus_addr, 32'h100);
    tick();
    bus_ready = 1'b0; bus_ack = 1'b0; settle();
    check("t1_done_wr", {31'b0, bus_wr}, 32'd0);
    check("t1_done_addr", bus_addr, 32'd0);
    check("t1_done_count", 32'(dut.u_fifo.count_o), 32'd0);
    tick();

    // Fill the buffer with the bus held off; fifth write stalls
    for (int i = 0; i < 4; i++) begin
      wr(32'h10 + 32'(4 * i), 32'(i + 1)); settle();
      check("t2_accept", {31'b0, rw_wait}, 32'd0);
      tick();
    end
    wr(32'h20, 32'd5); settle();
    check("t2_full_wait", {31'b0, rw_wait}, 32'd1);
    tick();
    bus_ack = 1'b1; bus_ready = 1'b1; settle();
    check("t2_drain_same_cycle_wait", {31'b0, rw_wait}, 32'd1);
    check("t2_drain_addr", bus_addr, 32'h10);
    check("t2_drain_wdata", bus_wdata, 32'd1);
    tick();
    bus_ack = 1'b0; bus_ready = 1'b0; settle();
    check("t2_fifth_accept", {31'b0, rw_wait}, 32'd0);
    tick();
    wr_req = 1'b0; settle();
    check("t2_count_full", 32'(dut.u_fifo.count_o), 32'd4);
    check("t2_bus_req", {31'b0, bus_req}, 32'd1);
    bus_ack = 1'b1; bus_ready = 1'b1; settle();
    drain_expect("t2_d1", 32'h14, 32'd2);
    drain_expect("t2_d2", 32'h18, 32'd3);
    drain_expect("t2_d3", 32'h1C, 32'd4);
    drain_expect("t2_d4", 32'h20, 32'd5);
    bus_ack = 1'b0; bus_ready = 1'b0; settle();
    check("t2_empty", 32'(dut.u_fifo.count_o), 32'd0);

    // Forwarding returns the newest duplicate, including while draining
    wr(32'h200, 32'hAA); tick();
    wr(32'h200, 32'hBB); tick();
    wr_req = 1'b0; rd_req = 1'b1; addr = 32'h200; settle();
    check("t3_fwd_data", rd_data, 32'hBB);
    check("t3_fwd_wait", {31'b0, rw_wait}, 32'd0);
    check("t3_fwd_no_bus_rd", {31'b0, bus_rd}, 32'd0);
    tick();
    bus_ack = 1'b1; settle();
    check("t3_drain_wdata", bus_wdata, 32'hAA);
    check("t3_fwd_during_drain", rd_data, 32'hBB);
    tick();
    rd_req = 1'b0; bus_ready = 1'b1; settle();
    check("t3_drain2_wdata", bus_wdata, 32'hAA);
    tick();
    drain_expect("t3_d2", 32'h200, 32'hBB);
    bus_ready = 1'b0; settle();

    // Read miss, bus_ready on the third strobe cycle
    rd_req = 1'b1; addr = 32'h300; bus_rdata = 32'hDEADBEEF; settle();
    check("t4_miss_wait", {31'b0, rw_wait}, 32'd1);
    check("t4_pre_addr", bus_addr, 32'd0);
    check("t4_pre_req", {31'b0, bus_req}, 32'd0);
    tick();
    check("t4_s1_rd", {31'b0, bus_rd}, 32'd1);
    check("t4_s1_addr", bus_addr, 32'h300);
    check("t4_s1_wait", {31'b0, rw_wait}, 32'd1);
    tick();
    check("t4_s2_wait", {31'b0, rw_wait}, 32'd1);
    tick();
    bus_ready = 1'b1; settle();
    check("t4_s3_wait", {31'b0, rw_wait}, 32'd0);
    check("t4_s3_data", rd_data, 32'hDEADBEEF);
    tick();
    rd_req = 1'b0; bus_ready = 1'b0; settle();
    check("t4_post_addr", bus_addr, 32'd0);
    check("t4_post_req", {31'b0, bus_req}, 32'd0);
    bus_ack = 1'b0;
    tick();

    // Write in flight, then read miss, then remaining write
    wr(32'h500, 32'h55); tick();
    wr(32'h504, 32'h66); tick();
    wr_req = 1'b0; settle();
    check("t5_wreq", {31'b0, bus_req}, 32'd1);
    bus_ack = 1'b1; rd_req = 1'b1; addr = 32'h400; bus_rdata = 32'h12345678; settle();
    check("t5_w1_addr", bus_addr, 32'h500);
    check("t5_w1_rw_wait", {31'b0, rw_wait}, 32'd1);
    tick();
    bus_ready = 1'b1; settle();
    check("t5_w1_done_wr", {31'b0, bus_wr}, 32'd1);
    check("t5_w1_done_rd", {31'b0, bus_rd}, 32'd0);
    tick();
    bus_ready = 1'b0; settle();
    check("t5_gap1_req", {31'b0, bus_req}, 32'd0);
    tick();
    bus_ready = 1'b1; settle();
    check("t5_rd_strobe", {31'b0, bus_rd}, 32'd1);
    check("t5_rd_addr", bus_addr, 32'h400);
    check("t5_rd_data", rd_data, 32'h12345678);
    check("t5_rd_wait", {31'b0, rw_wait}, 32'd0);
    tick();
    rd_req = 1'b0; bus_ready = 1'b0; settle();
    check("t5_gap2_req", {31'b0, bus_req}, 32'd0);
    tick();
    bus_ready = 1'b1; settle();
    check("t5_w2_wr", {31'b0, bus_wr}, 32'd1);
    check("t5_w2_addr", bus_addr, 32'h504);
    check("t5_w2_wdata", bus_wdata, 32'h66);
    tick();
    bus_ready = 1'b0; settle();
    check("t5_count", 32'(dut.u_fifo.count_o), 32'd0);
    check("t5_idle_req", {31'b0, bus_req}, 32'd0);
    bus_ack = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write transfer
    wr(32'h600, 32'd1); tick();
    wr(32'h604, 32'd2); tick();
    wr(32'h608, 32'd3); tick();
    wr_req = 1'b0; bus_ack = 1'b1; settle();
    tick();
    check("t6_in_write", {31'b0, bus_wr}, 32'd1);
    check("t6_count3", 32'(dut.u_fifo.count_o), 32'd3);
    #2;
    Nrst = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, bus_req}, 32'd0);
    check("t6_rst_wr", {31'b0, bus_wr}, 32'd0);
    check("t6_rst_addr", bus_addr, 32'd0);
    check("t6_rst_wdata", bus_wdata, 32'd0);
    check("t6_rst_count", 32'(dut.u_fifo.count_o), 32'd0);
    tick();
    Nrst = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check("t6_post_quiet", {29'b0, bus_req, bus_wr, bus_rd}, 32'd0);
      tick();
    end
    check("t6_post_count", 32'(dut.u_fifo.count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dcache_wbuf.md
Name: dcache_wbuf

Overview:
Posted-write buffer between the data cache's bus master port and the shared system bus. Store traffic from the data cache is queued in a small FIFO and drained to the bus, so the memory stage stalls only when the buffer is full. Reads check the FIFO first and are forwarded from it on a hit; on a miss they go to the bus. All bus outputs are zero whenever the block does not own the bus, so they can be OR-combined with the other bus masters.

Parameters:
DEPTH, 4, number of buffered word writes (power of two, at least 2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  system clock
Nrst  in  1  asynchronous active-low reset
addr  in  32  request address, word-granular; addr[1:0] ignored
rd_req  in  1  read request, held until rw_wait is low
wr_req  in  1  write request, held until rw_wait is low
wr_data  in  32  write data
rd_data  out  32  read data, valid when rd_req=1 and rw_wait=0
rw_wait  out  1  stall to requester
bus_req  out  1  bus request to arbiter
bus_ack  in  1  grant from arbiter (combinational)
bus_addr  out  32  bus address, 0 when not transferring
bus_wdata  out  32  bus write data, 0 when not writing
bus_rd  out  1  bus read strobe
bus_wr  out  1  bus write strobe
bus_rdata  in  32  bus read data
bus_ready  in  1  slave completion for the current strobe

Behaviour:
- Reset (Nrst=0, asynchronous):
  - FIFO empty, count=0, FSM=IDLE.
  - bus_req, bus_rd, bus_wr, bus_addr, bus_wdata, rd_data all 0; rw_wait=0.
  - Reset mid-transaction discards all entries and aborts the bus cycle with no further strobes.
- Entries hold {addr[31:2], data}. count is registered and ranges 0..DEPTH; pointers wrap modulo DEPTH.
- Write accept:
  - With wr_req=1 and count<DEPTH: rw_wait=0 in the same cycle and the entry is enqueued at the clock edge.
  - With count==DEPTH: rw_wait=1. A drain completing in that same cycle does not free a slot until the next cycle.
  - No merging: duplicate addresses occupy separate entries.
- Read forwarding:
  - With rd_req=1, the entry address of every valid entry is compared combinationally against addr[31:2].
  - On a hit, the newest matching entry's data drives rd_data with rw_wait=0, zero latency.
  - Forwarding is valid while that entry is being drained.
- Read miss:
  - rw_wait=1 and the FSM services the read before the next drain; a drain already in progress completes first.
  - rw_wait falls in the cycle bus_ready=1 with bus_rd=1, with rd_data=bus_rdata combinationally.
  - The requester holds addr and rd_req stable throughout.
- rd_req and wr_req together is illegal; write wins and the read is ignored that cycle.
- FSM states:
  - IDLE: a pending read miss goes to RREQ; else count>0 goes to WREQ.
  - WREQ/RREQ: bus_req=1. When bus_ack=1, drive strobe, address and data in the same cycle, treating that cycle as the strobe cycle (state becomes WRITE/READ at the edge).
  - WRITE: bus_wr=1, bus_addr={head.addr,2'b00}, bus_wdata=head.data, bus_req held. On bus_ready, dequeue the head and go to IDLE.
  - READ: bus_rd=1, bus_addr={addr[31:2],2'b00}, bus_req held. On bus_ready, go to IDLE.
  - bus_ack dropping mid-transfer is illegal (the arbiter holds the grant while bus_req stays high).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- One bus transfer per grant; bus_req deasserts for at least one cycle between transfers.

Decomposition:
- Shared package: DEPTH default and FSM state encoding (IDLE, WREQ, WRITE, RREQ, READ).
- One natural sub-module, wbuf_fifo: storage, pointers, count, full/empty flags, and the newest-match CAM lookup returning hit and data.
- The bus FSM stays in dcache_wbuf.

Test Plan:
- Write A=0x100/D=0x11, bus_ack=1, bus_ready after 2 cycles → rw_wait stays 0; exactly one bus_wr cycle group with bus_addr=0x100, bus_wdata=0x11; count returns to 0.
- Hold bus_ack=0 and issue 5 writes → first 4 accepted; the 5th sees rw_wait=1 until one drain completes, then is accepted the cycle after.
- Write 0x200←0xAA, then 0x200←0xBB, then read 0x200 while the bus is held off → rd_data=0xBB, rw_wait=0, no bus_rd.
- Read 0x300 miss with bus_rdata=0xDEADBEEF, bus_ready on the 3rd strobe cycle → rw_wait=1 until that cycle; rd_data=0xDEADBEEF; bus_addr=0 outside the strobe.
- 2 writes pending plus read miss to 0x400 → the in-flight write completes, then the read is serviced, then the remaining write drains; bus_req drops between transfers.
- Assert Nrst=0 during WRITE with 3 entries queued → all bus outputs 0 immediately; after release, no bus activity with count=0.
